wave_sequencer: RTL

//   Segment sequencer for the waveform generator. Holds a small program table of
//   {wave_sel, freq_ctrl, duration} entries and plays them in order, driving the

---
 rtl/wavegen_pkg.sv | 20 ++
 rtl/wave_seq_table.sv | 30 +++
 rtl/wave_sequencer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/wavegen_pkg.sv
// Shared constants and types for the waveform generator segment sequencer.
package wavegen_pkg;

   localparam logic [1:0] WAVE_NCO   = 2'b00;
   localparam logic [1:0] WAVE_CHIRP = 2'b01;
   localparam logic [1:0] WAVE_SAW   = 2'b10;
   localparam logic [1:0] WAVE_PULSE = 2'b11;

   localparam int unsigned SEQ_N  = 32;
   localparam int unsigned SEQ_DW = 16;

   typedef struct packed {
      logic [1:0]        sel;
      logic [SEQ_N-1:0]  freq;
      logic [SEQ_DW-1:0] dur;
   } seg_entry_t;

   typedef enum logic [1:0] {StIdle, StSetup, StRun, StDone} seq_state_e;

endpackage

// File: rtl/wave_seq_table.sv
// Segment program table: DEPTH entries of {sel, freq, dur}, one write port and one
// asynchronous read port. Contents are deliberately not reset.
module wave_seq_table
   import wavegen_pkg::*;
#(
   parameter int unsigned N     = 32,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned DW    = 16,
   localparam int unsigned A    = $clog2(DEPTH),
   localparam int unsigned W    = 2 + N + DW
) (
   input  logic         clk,
   input  logic         wr_en,
   input  logic [A-1:0] wr_addr,
   input  logic [W-1:0] wr_data,
   input  logic [A-1:0] rd_addr,
   output logic [W-1:0] rd_data
);

   logic [W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/wave_sequencer.sv
// Segment sequencer: plays table entries in order, resetting generator phase at each
// segment boundary. Define SEQ_LOOP_EN to repeat the program loop_cnt times (0 = forever).
module wave_sequencer
   import wavegen_pkg::*;
#(
   parameter int unsigned N     = 32,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned DW    = 16,
   localparam int unsigned A    = $clog2(DEPTH),
   localparam int unsigned W    = 2 + N + DW
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wr_en,
   input  logic [A-1:0] wr_addr,
   input  logic [W-1:0] wr_data,
   input  logic [A:0]   num_seg,
   input  logic [7:0]   loop_cnt,
   input  logic         start,
   input  logic         abort,
   output logic [1:0]   wave_sel,
   output logic [N-1:0] freq_ctrl,
   output logic         gen_rst,
   output logic [A-1:0] seg_idx,
   output logic         busy,
   output logic         done,
   output logic         wr_err
);

   seq_state_e   state_q, state_d;
   logic [A-1:0] seg_idx_q, seg_idx_d;
   logic [A:0]   num_seg_q, num_seg_d;
   logic [DW-1:0] cnt_q, cnt_d;
   logic [1:0]   wave_sel_q, wave_sel_d;
   logic [N-1:0] freq_q, freq_d;
   logic         gen_rst_q, gen_rst_d, busy_q, busy_d, done_q, done_d, wr_err_q, wr_err_d;
   logic [W-1:0] rd_data;
   logic [1:0]   rd_sel;
   logic [N-1:0] rd_freq;
   logic [DW-1:0] rd_dur;
   logic         busy_now, start_ok, last_run, last_seg, more_passes;

`ifdef SEQ_LOOP_EN
   logic [7:0]   pass_q, pass_d;
   // pass_q == 0 means loop forever; 1 means this is the final pass.
   assign more_passes = (pass_q != 8'd1);
`else
   logic unused_loop_cnt;
   assign unused_loop_cnt = ^loop_cnt;
   assign more_passes = 1'b0;
`endif

   assign rd_sel   = rd_data[W-1 -: 2];
   assign rd_freq  = rd_data[N+DW-1 -: N];
   assign rd_dur   = rd_data[DW-1:0];
   assign busy_now = (state_q == StSetup) || (state_q == StRun);
   assign start_ok = (num_seg != '0) && (num_seg <= (A+1)'(DEPTH));
   assign last_run = (cnt_q == DW'(1));
   assign last_seg = ((A+1)'(seg_idx_q) == num_seg_q - (A+1)'(1));

   wave_seq_table #(
      .N     (N),
      .DEPTH (DEPTH),
      .DW    (DW)
   ) u_table (
      .clk     (clk),
      .wr_en   (wr_en && !busy_now),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (seg_idx_d),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         seg_idx_q  <= '0;
         num_seg_q  <= '0;
         cnt_q      <= '0;
         wave_sel_q <= '0;
         freq_q     <= '0;
         gen_rst_q  <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         wr_err_q   <= 1'b0;
`ifdef SEQ_LOOP_EN
         pass_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         seg_idx_q  <= seg_idx_d;
         num_seg_q  <= num_seg_d;
         cnt_q      <= cnt_d;
         wave_sel_q <= wave_sel_d;
         freq_q     <= freq_d;
         gen_rst_q  <= gen_rst_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         wr_err_q   <= wr_err_d;
`ifdef SEQ_LOOP_EN
         pass_q     <= pass_d;
`endif
      end
   end

   // Kept free of rd_data so the table read address does not loop back on itself.
   always_comb begin
      state_d   = state_q;
      seg_idx_d = seg_idx_q;
      num_seg_d = num_seg_q;
`ifdef SEQ_LOOP_EN
      pass_d    = pass_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (start_ok) begin
                  state_d   = StSetup;
                  seg_idx_d = '0;
                  num_seg_d = num_seg;
`ifdef SEQ_LOOP_EN
                  pass_d    = loop_cnt;
`endif
               end else begin
                  state_d = StDone;
               end
            end
         end
         StSetup: state_d = StRun;
         StRun: begin
            if (last_run) begin
               if (!last_seg) begin
                  state_d   = StSetup;
                  seg_idx_d = seg_idx_q + A'(1);
               end else if (more_passes) begin
                  state_d   = StSetup;
                  seg_idx_d = '0;
`ifdef SEQ_LOOP_EN
                  pass_d    = (pass_q == 8'd0) ? 8'd0 : pass_q - 8'd1;
`endif
               end else begin
                  state_d   = StDone;
                  seg_idx_d = '0;
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
      if (abort) begin
         state_d   = StIdle;
         seg_idx_d = '0;
      end
   end

   // Duration counter: loaded in SETUP from the current entry, zero duration runs once.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == StSetup) begin
         cnt_d = (rd_dur == '0) ? DW'(1) : rd_dur;
      end else if (state_q == StRun) begin
         cnt_d = cnt_q - DW'(1);
      end
   end

   always_comb begin
      wave_sel_d = '0;
      freq_d     = '0;
      gen_rst_d  = 1'b1;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      wr_err_d   = wr_en && busy_now;
      unique case (state_d)
         StSetup: begin
            wave_sel_d = rd_sel;
            freq_d     = rd_freq;
            busy_d     = 1'b1;
         end
         StRun: begin
            wave_sel_d = wave_sel_q;
            freq_d     = freq_q;
            gen_rst_d  = 1'b0;
            busy_d     = 1'b1;
         end
         StDone:  done_d = 1'b1;
         default: ;
      endcase
   end

   assign wave_sel  = wave_sel_q;
   assign freq_ctrl = freq_q;
   assign gen_rst   = gen_rst_q;
   assign seg_idx   = seg_idx_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign wr_err    = wr_err_q;

endmodule
